mem_write_checker: RTL

Parametrised, self-checking scoreboard for the CPU data-memory write bus. Holds a FIFO of up to DEPTH expected (address, data) store transactions, compares every cycle with memwrite high against the queue head in order, and reports a sticky pass/fail verdict. A cycle timeout catches hung programs. Sits beside `cpu` in every program bench, replacing single-point end-of-run checks with an in-order check of every store.

---
 rtl/mem_write_checker.sv | 104 ++++++++++
 1 files changed

// File: rtl/mem_write_checker.sv
// mem_write_checker: in-order store scoreboard; exp_* pushes expected stores, memwrite/dataaddr/writedata are checked, done/pass/fail/err_code/match_cnt/fail_addr/fail_data report the verdict
module mem_write_checker #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 8,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              exp_valid,
  input  logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  output logic              exp_ready,
  input  logic              start,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] dataaddr,
  input  logic [DATA_W-1:0] writedata,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [1:0]        err_code,
  output logic [15:0]       match_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO = TW'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;
  state_t state_q;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic [TW-1:0] tcnt_q;
  logic [1:0] err_q;
  logic [15:0] match_q;
  logic [ADDR_W-1:0] fa_q;
  logic [DATA_W-1:0] fd_q;
  logic empty, full, push, hit;
  assign empty = wr_q == rd_q;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign exp_ready = !full && (state_q == IDLE || state_q == RUN);
  assign push = exp_valid && exp_ready && !clear;
  assign hit = addr_mem[rd_q[AW-1:0]] == dataaddr && data_mem[rd_q[AW-1:0]] == writedata;
  assign pass = state_q == PASS;
  assign fail = state_q == FAIL;
  assign done = pass | fail;
  assign err_code = err_q;
  assign match_cnt = match_q;
  assign fail_addr = fa_q;
  assign fail_data = fd_q;
  always_ff @(posedge clk)
    if (push) begin
      addr_mem[wr_q[AW-1:0]] <= exp_addr;
      data_mem[wr_q[AW-1:0]] <= exp_data;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      tcnt_q <= '0;
      err_q <= '0;
      match_q <= '0;
      fa_q <= '0;
      fd_q <= '0;
    end else if (clear) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      tcnt_q <= '0;
      err_q <= '0;
      match_q <= '0;
      fa_q <= '0;
      fd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + (AW+1)'(1);
      case (state_q)
        IDLE: if (start) begin
          state_q <= RUN;
          tcnt_q <= '0;
        end
        RUN: if (memwrite) begin
          if (empty || !hit) begin
            state_q <= FAIL;
            err_q <= empty ? 2'd2 : 2'd1;
            fa_q <= dataaddr;
            fd_q <= writedata;
          end else begin
            rd_q <= rd_q + (AW+1)'(1);
            match_q <= match_q + 16'(match_q != 16'hFFFF);
            tcnt_q <= '0;
          end
        end else if (empty) begin
          if (!push) state_q <= PASS;
        end else if (tcnt_q + TW'(1) == TO) begin
          state_q <= FAIL;
          err_q <= 2'd3;
        end else tcnt_q <= tcnt_q + TW'(1);
        default: ;
      endcase
    end
endmodule
